// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: rows written in row-major order into one bank
// while the other bank is read out column-major.
module dct_transpose_buffer #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] data_out,
  output logic [2:0]   out_row,
  output logic [2:0]   out_col,
  output logic         out_last
);

  logic [n-1:0] r_mem [2][64];

  logic       r_wsel, r_rsel;
  logic [5:0] r_wr_cnt, r_rd_cnt;
  logic [1:0] r_full;

  logic       w_wsel_nx, w_rsel_nx;
  logic [5:0] w_wr_cnt_nx, w_rd_cnt_nx;
  logic [1:0] w_full_nx;
  logic       w_wr_acc, w_rd_acc;
  logic [5:0] w_rd_addr;

  assign in_ready  = !r_full[r_wsel];
  assign out_valid = r_full[r_rsel];
  assign w_wr_acc  = in_valid && in_ready;
  assign w_rd_acc  = out_valid && out_ready;

  // Read counter walks rows fastest, so the stored row-major address is swapped.
  assign w_rd_addr = {r_rd_cnt[2:0], r_rd_cnt[5:3]};
  assign out_row   = r_rd_cnt[2:0];
  assign out_col   = r_rd_cnt[5:3];
  assign out_last  = out_valid && (r_rd_cnt == 6'd63);
  assign data_out  = out_valid ? r_mem[r_rsel][w_rd_addr] : '0;

  always_comb begin
    w_wsel_nx   = r_wsel;
    w_rsel_nx   = r_rsel;
    w_wr_cnt_nx = r_wr_cnt;
    w_rd_cnt_nx = r_rd_cnt;
    w_full_nx   = r_full;
    if (w_wr_acc) begin
      w_wr_cnt_nx = r_wr_cnt + 6'd1;
      if (r_wr_cnt == 6'd63) begin
        w_full_nx[r_wsel] = 1'b1;
        w_wsel_nx         = ~r_wsel;
      end
    end
    // A write sets a non-full bank and a read clears a full one, so both can apply.
    if (w_rd_acc) begin
      w_rd_cnt_nx = r_rd_cnt + 6'd1;
      if (r_rd_cnt == 6'd63) begin
        w_full_nx[r_rsel] = 1'b0;
        w_rsel_nx         = ~r_rsel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wsel   <= 1'b0;
      r_rsel   <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_full   <= '0;
    end else begin
      r_wsel   <= w_wsel_nx;
      r_rsel   <= w_rsel_nx;
      r_wr_cnt <= w_wr_cnt_nx;
      r_rd_cnt <= w_rd_cnt_nx;
      r_full   <= w_full_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wsel][r_wr_cnt] <= data_in;
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Self-checking bench for dct_transpose_buffer: block-queue model compared every
// cycle, plus directed literal checks on transpose order, latency and backpressure.
module tb_dct_transpose_buffer;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] data_in = '0;
  logic         in_ready, out_valid, out_last;
  logic [N-1:0] data_out;
  logic [2:0]   out_row, out_col;

  dct_transpose_buffer #(.n(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of completed blocks (at most two), a filling block, read index.
  typedef logic [N-1:0] blk_t [64];
  blk_t m_done[$];
  blk_t m_cur;
  int   m_wn = 0;
  int   m_rj = 0;
  bit   m_accw, m_accr;
  logic [N-1:0] got[$];

  always @(posedge clk) begin
    if (reset) begin
      m_done.delete();
      m_wn = 0;
      m_rj = 0;
    end else begin
      m_accw = in_valid && (m_done.size() < 2);
      m_accr = out_ready && (m_done.size() > 0);
      if (m_accr) begin
        m_rj++;
        if (m_rj == 64) begin
          m_rj = 0;
          void'(m_done.pop_front());
        end
      end
      if (m_accw) begin
        m_cur[m_wn] = data_in;
        m_wn++;
        if (m_wn == 64) begin
          m_wn = 0;
          m_done.push_back(m_cur);
        end
      end
    end
  end

  bit           p_stall = 1'b0;
  logic [N-1:0] p_d;
  logic [2:0]   p_row, p_col;
  logic         p_last;
  bit           e_v, e_r;
  logic [N-1:0] e_d;

  always @(negedge clk) begin
    e_v = m_done.size() > 0;
    e_r = m_done.size() < 2;
    e_d = e_v ? m_done[0][(m_rj % 8) * 8 + m_rj / 8] : '0;
    check("in_ready", in_ready, e_r);
    check("out_valid", out_valid, e_v);
    check("data_out", data_out, e_d);
    check("out_row", out_row, m_rj % 8);
    check("out_col", out_col, m_rj / 8);
    check("out_last", out_last, e_v && (m_rj == 63));
    if (p_stall && !reset) begin
      check("stall_data", data_out, p_d);
      check("stall_rowcol", {out_row, out_col}, {p_row, p_col});
      check("stall_last", out_last, p_last);
    end
    if (reset) got.delete();
    else if (out_valid && out_ready) got.push_back(data_out);
    p_stall = !reset && out_valid && !out_ready;
    p_d = data_out; p_row = out_row; p_col = out_col; p_last = out_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] w, output int waits);
    in_valid = 1'b1;
    data_in  = w;
    waits    = 0;
    while (!in_ready && waits < 500) begin
      tick();
      waits++;
    end
    if (waits >= 500) check("send_timeout", waits, 0);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(output int cyc);
    out_ready = 1'b1;
    cyc = 0;
    while (m_done.size() > 0 && cyc < 1000) begin
      tick();
      cyc++;
    end
    if (cyc >= 1000) check("drain_timeout", cyc, 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
  endtask

  bit sender_done;

  initial begin
    int w, tot, cyc;
    #1;
    do_reset(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_out_last", out_last, 0);

    // Single block: 0..63
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k == 63) check("pre_last_out_valid", out_valid, 0);
      send(N'(k), w);
    end
    check("lat_out_valid", out_valid, 1);
    check("lat_data_out", data_out, 0);
    check("lat_rowcol", {out_row, out_col}, 0);
    drain(cyc);
    check("single_drain_cycles", cyc, 64);
    check("single_count", got.size(), 64);
    if (got.size() == 64) begin
      check("single_seq0", got[0], 0);
      check("single_seq1", got[1], 8);
      check("single_seq7", got[7], 56);
      check("single_seq8", got[8], 1);
      check("single_seq63", got[63], 63);
    end

    // Streaming 4 blocks
    got.delete();
    tot = 0;
    for (int i = 0; i < 256; i++) begin
      send(N'(1000 + i), w);
      tot += w;
    end
    check("stream_in_ready_waits", tot, 0);
    drain(cyc);
    check("stream_tail_cycles", cyc, 64);
    check("stream_count", got.size(), 256);
    if (got.size() == 256) begin
      check("stream_blk1_first", got[64], 1064);
      check("stream_last", got[255], 1255);
    end

    // Backpressure
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 128; i++) send(N'(2000 + i), w);
    in_valid = 1'b1;
    data_in  = N'(2128);
    for (int i = 0; i < 4; i++) tick();
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    send(N'(2128), w);
    check("bp_wait_cycles", w, 64);
    for (int i = 129; i < 192; i++) send(N'(2000 + i), w);
    drain(cyc);
    check("bp_count", got.size(), 192);
    if (got.size() == 192) begin
      check("bp_blk3_r0c0", got[128], 2128);
      check("bp_blk3_r1c0", got[129], 2136);
    end

    // Random output stalls
    got.delete();
    sender_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 192; i++) send(N'(3000 + i), w);
        sender_done = 1'b1;
      end
      begin
        for (int c = 0; c < 5000 && !sender_done; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    check("rand_sender_done", sender_done, 1);
    drain(cyc);
    check("rand_count", got.size(), 192);
    if (got.size() == 192) begin
      check("rand_first", got[0], 3000);
      check("rand_last", got[191], 3191);
    end

    // Mid-block reset with a full bank pending
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) send(N'(4000 + i), w);
    for (int i = 0; i < 30; i++) send(N'(5000 + i), w);
    check("pre_rst_out_valid", out_valid, 1);
    do_reset(1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) send(N'(6000 + i), w);
    drain(cyc);
    check("mid_rst_count", got.size(), 64);
    if (got.size() == 64) begin
      check("mid_rst_first", got[0], 6000);
      check("mid_rst_second", got[1], 6008);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
